intersection_phase_sched: RTL and testbench

- Sequences a two-road (NS/EW) signalised intersection: drives both three-lamp light sets and both pedestrian walk lamps.
- Adds all-red clearance, latched pedestrian requests and emergency-vehicle preemption.
- Sits above the per-direction lamp drivers and owns the 1 s timebase.
- All durations are counted in timebase ticks.

---
 rtl/phase_pkg.sv | 57 +++++
 rtl/tick_gen.sv | 35 +++
 rtl/intersection_phase_sched.sv | 170 +++++++++++++++++
 tb/tb_intersection_phase_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_pkg
//  Purpose  : Phase codes, lamp vectors and sequencing helpers shared by the
//             intersection phase scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package phase_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } phase_t;

    // Lamp vector ordering is {red, yellow, green}
    localparam logic [2:0] c_LAMP_RED    = 3'b100;
    localparam logic [2:0] c_LAMP_YELLOW = 3'b010;
    localparam logic [2:0] c_LAMP_GREEN  = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    function automatic lamps_t decode_lamps(input phase_t s);
        lamps_t l;
        l.ns = c_LAMP_RED;
        l.ew = c_LAMP_RED;
        case (s)
            NS_GREEN:  l.ns = c_LAMP_GREEN;
            NS_YELLOW: l.ns = c_LAMP_YELLOW;
            EW_GREEN:  l.ew = c_LAMP_GREEN;
            EW_YELLOW: l.ew = c_LAMP_YELLOW;
            default:   ;
        endcase
        return l;
    endfunction

    function automatic phase_t next_phase(input phase_t s);
        phase_t n;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            default:   n = NS_GREEN;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Free-running divider emitting a one-clk tick every CLK_DIV clks,
//             with a synchronous clear that restarts the full period.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/intersection_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_phase_sched
//  Purpose  : NS/EW signal phase sequencer with all-red clearance, latched
//             pedestrian requests and emergency-vehicle preemption.
//  Revision : 1.0 - initial release
// ============================================================================
module intersection_phase_sched
    import phase_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 10,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ped_req_ns,
    input  logic             ped_req_ew,
    input  logic             emerg_req,
    input  logic             emerg_dir,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic             walk_ns,
    output logic             walk_ew,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] sec_left
);

    // Walk ends on the tick that consumes the WALK_T-th tick of green
    localparam logic [CNT_W-1:0] c_WALK_END = CNT_W'(GREEN_T - WALK_T + 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] phase_dur(input phase_t s);
        logic [CNT_W-1:0] d;
        case (s)
            NS_GREEN, EW_GREEN:   d = CNT_W'(GREEN_T);
            NS_YELLOW, EW_YELLOW: d = CNT_W'(YELLOW_T);
            default:              d = CNT_W'(ALLRED_T);
        endcase
        return d;
    endfunction

    phase_t           r_state;
    logic [CNT_W-1:0] r_sec_left;
    logic             r_ped_lat_ns;
    logic             r_ped_lat_ew;
    logic             r_walk_ns;
    logic             r_walk_ew;

    phase_t           w_state_nxt;
    phase_t           w_succ;
    logic [CNT_W-1:0] w_sec_nxt;
    logic             w_lat_ns_nxt;
    logic             w_lat_ew_nxt;
    logic             w_walk_ns_nxt;
    logic             w_walk_ew_nxt;
    logic             w_div_clr;
    logic             w_tick;
    logic             w_legal;
    logic             w_hold_ns;
    logic             w_hold_ew;
    logic             w_cut_ns;
    logic             w_cut_ew;
    lamps_t           w_lamps;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_div_clr),
        .tick  (w_tick)
    );

    assign w_legal   = (r_state <= ALLRED_B);
    assign w_hold_ns = emerg_req && !emerg_dir && (r_state == NS_GREEN);
    assign w_hold_ew = emerg_req &&  emerg_dir && (r_state == EW_GREEN);
    assign w_cut_ns  = emerg_req &&  emerg_dir && (r_state == NS_GREEN);
    assign w_cut_ew  = emerg_req && !emerg_dir && (r_state == EW_GREEN);
    assign w_succ    = next_phase(r_state);

    always_comb begin
        w_state_nxt   = r_state;
        w_sec_nxt     = r_sec_left;
        w_lat_ns_nxt  = r_ped_lat_ns | ped_req_ns;
        w_lat_ew_nxt  = r_ped_lat_ew | ped_req_ew;
        w_walk_ns_nxt = r_walk_ns;
        w_walk_ew_nxt = r_walk_ew;
        w_div_clr     = 1'b0;

        if (!w_legal) begin
            w_state_nxt   = ALLRED_B;
            w_sec_nxt     = CNT_W'(ALLRED_T);
            w_walk_ns_nxt = 1'b0;
            w_walk_ew_nxt = 1'b0;
        end else if (w_cut_ns) begin
            // Restart the divider so the preempt yellow runs full length
            w_state_nxt   = NS_YELLOW;
            w_sec_nxt     = CNT_W'(YELLOW_T);
            w_div_clr     = 1'b1;
            w_walk_ns_nxt = 1'b0;
        end else if (w_cut_ew) begin
            w_state_nxt   = EW_YELLOW;
            w_sec_nxt     = CNT_W'(YELLOW_T);
            w_div_clr     = 1'b1;
            w_walk_ew_nxt = 1'b0;
        end else if (w_hold_ns) begin
            w_walk_ns_nxt = 1'b0;
        end else if (w_hold_ew) begin
            w_walk_ew_nxt = 1'b0;
        end else if (w_tick) begin
            if (r_sec_left == c_ONE) begin
                w_state_nxt   = w_succ;
                w_sec_nxt     = phase_dur(w_succ);
                w_walk_ns_nxt = 1'b0;
                w_walk_ew_nxt = 1'b0;
                // A green about to be cut by preemption keeps its latch for later
                if ((w_succ == NS_GREEN) && !(emerg_req && emerg_dir)) begin
                    w_walk_ns_nxt = r_ped_lat_ns | ped_req_ns;
                    w_lat_ns_nxt  = 1'b0;
                end
                if ((w_succ == EW_GREEN) && !(emerg_req && !emerg_dir)) begin
                    w_walk_ew_nxt = r_ped_lat_ew | ped_req_ew;
                    w_lat_ew_nxt  = 1'b0;
                end
            end else begin
                w_sec_nxt = r_sec_left - c_ONE;
                if (r_sec_left == c_WALK_END) begin
                    w_walk_ns_nxt = 1'b0;
                    w_walk_ew_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ALLRED_B;
            r_sec_left   <= CNT_W'(ALLRED_T);
            r_ped_lat_ns <= 1'b0;
            r_ped_lat_ew <= 1'b0;
            r_walk_ns    <= 1'b0;
            r_walk_ew    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sec_left   <= w_sec_nxt;
            r_ped_lat_ns <= w_lat_ns_nxt;
            r_ped_lat_ew <= w_lat_ew_nxt;
            r_walk_ns    <= w_walk_ns_nxt;
            r_walk_ew    <= w_walk_ew_nxt;
        end
    end

    assign w_lamps = decode_lamps(r_state);
    assign {ns_red, ns_yellow, ns_green} = w_lamps.ns;
    assign {ew_red, ew_yellow, ew_green} = w_lamps.ew;
    assign walk_ns  = r_walk_ns;
    assign walk_ew  = r_walk_ew;
    assign phase    = r_state;
    assign sec_left = r_sec_left;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intersection_phase_sched
//  Purpose  : Scoreboard bench; expected phase/walk events are queued by the
//             stimulus and matched by a monitor on every output change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_sched;

    localparam int CLK_DIV  = 4;
    localparam int GREEN_T  = 5;
    localparam int YELLOW_T = 2;
    localparam int ALLRED_T = 1;
    localparam int WALK_T   = 3;
    localparam int CNT_W    = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ped_req_ns = 1'b0;
    logic             ped_req_ew = 1'b0;
    logic             emerg_req = 1'b0;
    logic             emerg_dir = 1'b0;
    logic             ns_red, ns_yellow, ns_green;
    logic             ew_red, ew_yellow, ew_green;
    logic             walk_ns, walk_ew;
    logic [2:0]       phase;
    logic [CNT_W-1:0] sec_left;

    intersection_phase_sched #(
        .CLK_DIV  (CLK_DIV),
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .WALK_T   (WALK_T),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
        .emerg_req  (emerg_req),
        .emerg_dir  (emerg_dir),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .phase      (phase),
        .sec_left   (sec_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int wns;
        int wew;
        int sec;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    bit   counting = 1'b0;

    always @(posedge clk) if (counting) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic push(input int ph, input int wns, input int wew, input int sec, input int gap);
        exp_t e;
        e.ph = ph; e.wns = wns; e.wew = wew; e.sec = sec; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic at_edge(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    // {ns r,y,g , ew r,y,g} expected for each phase code
    function automatic logic [5:0] exp_lamps(input logic [2:0] p);
        case (p)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    logic [4:0] prev_vec = {3'd5, 2'b00};
    logic [4:0] cur_vec;
    int         last_edge = 0;
    exp_t       pe;

    always @(negedge clk) begin
        if (counting) begin
            check("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, exp_lamps(phase));
            check("both_nonred", (!ns_red && !ew_red), 0);
            cur_vec = {phase, walk_ns, walk_ew};
            if (cur_vec !== prev_vec) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got phase/walk %b, nothing expected (edge %0d)", cur_vec, edge_cnt);
                end else begin
                    pe = exp_q.pop_front();
                    check("ev_phase", phase, pe.ph);
                    check("ev_walk_ns", walk_ns, pe.wns);
                    check("ev_walk_ew", walk_ew, pe.wew);
                    check("ev_sec_left", sec_left, pe.sec);
                    check("ev_gap", edge_cnt - last_edge, pe.gap);
                end
                prev_vec  = cur_vec;
                last_edge = edge_cnt;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: stimulus did not complete by time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Free run: one full 64-clk cycle
        push(0, 0, 0, 5, 4);
        push(1, 0, 0, 2, 20);
        push(2, 0, 0, 1, 8);
        push(3, 0, 0, 5, 4);
        push(4, 0, 0, 2, 20);
        push(5, 0, 0, 1, 8);
        push(0, 0, 0, 5, 4);
        repeat (3) @(posedge clk);
        #2;
        reset    = 1'b0;
        counting = 1'b1;
        #1;
        check("rst_phase", phase, 5);
        check("rst_sec_left", sec_left, ALLRED_T);
        check("rst_walk", {walk_ns, walk_ew}, 0);

        // EW pedestrian pulse during NS_GREEN
        at_edge(69);
        ped_req_ew = 1'b1;
        push(1, 0, 0, 2, 20);
        push(2, 0, 0, 1, 8);
        push(3, 0, 1, 5, 4);
        push(3, 0, 0, 2, 12);
        push(4, 0, 0, 2, 8);
        at_edge(70);
        ped_req_ew = 1'b0;

        // Second pulse inside EW_GREEN waits for the next EW_GREEN
        at_edge(113);
        ped_req_ew = 1'b1;
        push(5, 0, 0, 1, 8);
        push(0, 0, 0, 5, 4);
        push(1, 0, 0, 2, 20);
        push(2, 0, 0, 1, 8);
        push(3, 0, 1, 5, 4);
        push(3, 0, 0, 2, 12);
        push(4, 0, 0, 2, 8);
        push(5, 0, 0, 1, 8);
        push(0, 0, 0, 5, 4);
        at_edge(114);
        ped_req_ew = 1'b0;

        // Preempt toward EW while NS is green
        at_edge(200);
        check("pre_cut_sec_left", sec_left, 4);
        emerg_req = 1'b1;
        emerg_dir = 1'b1;
        push(1, 0, 0, 2, 5);
        push(2, 0, 0, 1, 8);
        push(3, 0, 0, 5, 4);
        at_edge(233);
        check("hold_ew_phase", phase, 3);
        check("hold_ew_sec_left", sec_left, 5);

        // Flip preempt to NS: EW cut, then release
        at_edge(235);
        emerg_dir = 1'b0;
        push(4, 0, 0, 2, 23);
        push(5, 0, 0, 1, 8);
        push(0, 1, 0, 5, 4);
        at_edge(236);
        emerg_req = 1'b0;
        at_edge(237);
        ped_req_ns = 1'b1;
        at_edge(238);
        ped_req_ns = 1'b0;

        // Hold NS green with walk active
        at_edge(256);
        check("pre_hold_sec_left", sec_left, 3);
        check("pre_hold_walk_ns", walk_ns, 1);
        emerg_req = 1'b1;
        push(0, 0, 0, 3, 9);
        at_edge(270);
        check("hold_ns_sec_left", sec_left, 3);
        check("hold_ns_walk_ns", walk_ns, 0);
        emerg_req = 1'b0;
        push(1, 0, 0, 2, 23);
        push(2, 0, 0, 1, 8);
        push(3, 0, 0, 5, 4);

        // Latch NS request, then reset mid EW_GREEN
        at_edge(294);
        ped_req_ns = 1'b1;
        at_edge(295);
        ped_req_ns = 1'b0;
        at_edge(300);
        push(5, 0, 0, 1, 8);
        push(0, 0, 0, 5, 7);
        reset = 1'b1;
        #1;
        check("midrst_phase", phase, 5);
        check("midrst_red", {ns_red, ew_red}, 2'b11);
        check("midrst_walk", {walk_ns, walk_ew}, 0);
        check("midrst_sec_left", sec_left, ALLRED_T);
        at_edge(303);
        reset = 1'b0;

        at_edge(320);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
